// File: rtl/student_tlul_socket_1n.sv
// ---------------------------------------------------------------------------
// tlul_pkg: minimal TL-UL channel structs and opcodes used by the socket.
//
// student_tlul_socket_1n: one TL-UL host to NUM devices.
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   tl_host_i    host A channel plus host d_ready
//   tl_host_o    host D channel plus a_ready
//   tl_device_o  per-device D channels plus a_ready (inputs to the socket)
//   tl_device_i  per-device A channels plus d_ready (outputs of the socket)
//
// Handshake rule on every channel: a beat transfers in a cycle where both
// valid and ready are high at the rising clock edge. valid never waits on
// ready. This socket adds no buffering; A and D pass through combinationally.
//
// The device-select field a_address[SEL_MSB:SEL_LSB] picks the device. Any
// value >= NUM goes to an internal error responder (ERR). Requests to the
// device currently in flight are admitted up to MAX_OUT outstanding. A
// request to any other target waits until every outstanding response has
// returned, which keeps D responses in request order.
// ---------------------------------------------------------------------------
package tlul_pkg;
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_tlul_socket_1n #(
  parameter int NUM     = 2,
  parameter int SEL_MSB = 23,
  parameter int SEL_LSB = 20,
  parameter int MAX_OUT = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  tlul_pkg::tl_h2d_t           tl_host_i,
  output tlul_pkg::tl_d2h_t           tl_host_o,
  input  tlul_pkg::tl_d2h_t [NUM-1:0] tl_device_o,
  output tlul_pkg::tl_h2d_t [NUM-1:0] tl_device_i
);
  import tlul_pkg::*;

  localparam int SW = SEL_MSB - SEL_LSB + 1;
  // Index width holds device numbers 0..15 plus the ERR code (NUM <= 16).
  localparam int IW = 5;
  localparam logic [IW-1:0] ERR = IW'(NUM);
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  typedef enum logic {E_IDLE, E_RESP} err_state_e;

  err_state_e    err_state;
  logic [IW-1:0] cur;
  logic [CW-1:0] cnt;
  logic [7:0]    err_source;
  logic [1:0]    err_size;
  logic          err_is_get;

  logic [SW-1:0] sel;
  logic [IW-1:0] tgt;
  logic          allow;
  logic          dev_a_ready;
  logic          host_a_ready;
  logic          host_d_valid;
  logic          a_hs;
  logic          d_hs;
  tl_d2h_t       d_sel;

  assign sel = tl_host_i.a_address[SEL_MSB:SEL_LSB];
  assign tgt = (IW'(sel) >= ERR) ? ERR : IW'(sel);

  // Admission uses the registered count, so a target switch granted on the
  // last drain beat only takes effect the following cycle.
  assign allow = (cnt == '0) || ((tgt == cur) && (tgt != ERR) && (cnt < CNT_MAX));

  always_comb begin
    dev_a_ready = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (tgt == IW'(i)) dev_a_ready = tl_device_o[i].a_ready;
    end
  end

  assign host_a_ready = rst_ni && allow &&
                        ((tgt == ERR) ? (err_state == E_IDLE) : dev_a_ready);
  assign a_hs = tl_host_i.a_valid && host_a_ready;

  // A channel fans out to every device; only the selected, admitted one
  // sees a_valid. Only the in-flight device may return D beats.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      tl_device_i[i]         = tl_host_i;
      tl_device_i[i].a_valid = rst_ni && tl_host_i.a_valid && allow && (tgt == IW'(i));
      tl_device_i[i].d_ready = rst_ni && tl_host_i.d_ready && (cur == IW'(i));
    end
  end

  always_comb begin
    d_sel = '0;
    if (cur == ERR) begin
      d_sel.d_valid  = (err_state == E_RESP);
      d_sel.d_opcode = err_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      d_sel.d_size   = err_size;
      d_sel.d_source = err_source;
      d_sel.d_error  = 1'b1;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (cur == IW'(i)) d_sel = tl_device_o[i];
      end
    end
  end

  assign host_d_valid = rst_ni && d_sel.d_valid;
  assign d_hs         = host_d_valid && tl_host_i.d_ready;

  always_comb begin
    tl_host_o         = d_sel;
    tl_host_o.d_valid = host_d_valid;
    tl_host_o.a_ready = host_a_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur        <= '0;
      cnt        <= '0;
      err_state  <= E_IDLE;
      err_source <= '0;
      err_size   <= '0;
      err_is_get <= 1'b0;
    end else begin
      if (a_hs) cur <= tgt;

      if (a_hs && !d_hs && (cnt != CNT_MAX)) cnt <= cnt + CW'(1);
      else if (d_hs && !a_hs && (cnt != '0)) cnt <= cnt - CW'(1);

      case (err_state)
        E_IDLE: begin
          if (a_hs && (tgt == ERR)) begin
            err_source <= tl_host_i.a_source;
            err_size   <= tl_host_i.a_size;
            err_is_get <= (tl_host_i.a_opcode == GET);
            err_state  <= E_RESP;
          end
        end
        E_RESP: begin
          // While an error is pending cur is ERR, so d_ready alone completes it.
          if (tl_host_i.d_ready) err_state <= E_IDLE;
        end
        default: err_state <= E_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_student_tlul_socket_1n.sv
// ---------------------------------------------------------------------------
// Bench for student_tlul_socket_1n (NUM=2, select field [23:20], MAX_OUT=4).
// A random host and two random device responders drive the socket. The
// reference keeps the in-order list of expected responses; its length is the
// outstanding count and the last accepted target is the current device.
// ---------------------------------------------------------------------------
module tb_student_tlul_socket_1n;
  import tlul_pkg::*;

  localparam int NUM     = 2;
  localparam int SEL_MSB = 23;
  localparam int SEL_LSB = 20;
  localparam int MAX_OUT = 4;
  localparam int ERR     = NUM;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_h2d_t           host_a;
  tl_d2h_t           host_d;
  tl_d2h_t [NUM-1:0] dev_d;
  tl_h2d_t [NUM-1:0] dev_a;

  student_tlul_socket_1n #(
    .NUM(NUM), .SEL_MSB(SEL_MSB), .SEL_LSB(SEL_LSB), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tl_host_i  (host_a),
    .tl_host_o  (host_d),
    .tl_device_o(dev_d),
    .tl_device_i(dev_a)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [1:0]  size;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t dev_q[NUM][$];
  logic dv_hold[NUM];
  int   cur_m;
  logic a_done;
  int   total = 0;
  int   bad   = 0;
  int   dready_pct;
  int   new_req_pct;
  int   unmapped_pct;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 50) $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt_of(input logic [31:0] addr);
    int f;
    f = int'(addr[SEL_MSB:SEL_LSB]);
    return (f >= NUM) ? ERR : f;
  endfunction

  function automatic logic [31:0] dev_data(input int i, input logic [31:0] addr);
    return addr ^ (32'hCAFE_0000 + 32'(i));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_request();
    int r;
    logic [3:0] f;
    r = $urandom_range(0, 99);
    if (r < unmapped_pct) f = 4'($urandom_range(2, 15));
    else if (r < unmapped_pct + (100 - unmapped_pct) / 2) f = 4'd0;
    else f = 4'd1;
    host_a.a_valid   = 1'b1;
    host_a.a_address = {8'($urandom), f, 20'($urandom)};
    r = $urandom_range(0, 2);
    host_a.a_opcode  = (r == 0) ? GET : (r == 1) ? PUT_FULL_DATA : PUT_PARTIAL_DATA;
    host_a.a_param   = 3'd0;
    host_a.a_size    = 2'($urandom_range(0, 2));
    host_a.a_source  = 8'($urandom);
    host_a.a_mask    = 4'hF;
    host_a.a_data    = $urandom;
  endtask

  task automatic check_cycle();
    int   t;
    int   n;
    logic allow;
    logic exp_ar;
    logic exp_dv;
    rsp_t e;
    rsp_t got;
    t = tgt_of(host_a.a_address);
    n = exp_q.size();
    allow = (n == 0) || ((t == cur_m) && (t != ERR) && (n < MAX_OUT));
    if (t != ERR) exp_ar = allow && dev_d[t].a_ready;
    else exp_ar = allow;
    if (cur_m == ERR) exp_dv = (n > 0);
    else exp_dv = dev_d[cur_m].d_valid;

    check("a_ready", host_d.a_ready, exp_ar);
    check("d_valid", host_d.d_valid, exp_dv);
    for (int i = 0; i < NUM; i++) begin
      check("dev_a_valid", dev_a[i].a_valid, host_a.a_valid && allow && (t == i));
      check("dev_d_ready", dev_a[i].d_ready, host_a.d_ready && (cur_m == i));
      check("dev_a_fwd", {dev_a[i].a_address, dev_a[i].a_source},
            {host_a.a_address, host_a.a_source});
    end

    // host D beat
    if (host_d.d_valid && host_a.d_ready) begin
      if (n == 0) check("d_unexpected", 1, 0);
      else begin
        e   = exp_q.pop_front();
        got = '{op: host_d.d_opcode, src: host_d.d_source, size: host_d.d_size,
                data: host_d.d_data, err: host_d.d_error};
        check("d_beat", got, e);
      end
    end
    // device-side beats
    for (int i = 0; i < NUM; i++) begin
      if (dev_a[i].d_ready && dev_d[i].d_valid && dev_q[i].size() > 0) begin
        void'(dev_q[i].pop_front());
        dv_hold[i] = 1'b0;
      end
      if (dev_a[i].a_valid && dev_d[i].a_ready) begin
        e.op   = (dev_a[i].a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
        e.src  = dev_a[i].a_source;
        e.size = dev_a[i].a_size;
        e.data = (dev_a[i].a_opcode == GET) ? dev_data(i, dev_a[i].a_address) : 32'd0;
        e.err  = 1'b0;
        dev_q[i].push_back(e);
      end
    end
    // host A beat: record what the host should eventually get back
    if (host_a.a_valid && host_d.a_ready) begin
      e.op   = (host_a.a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
      e.src  = host_a.a_source;
      e.size = host_a.a_size;
      e.err  = (t == ERR);
      e.data = ((t != ERR) && (host_a.a_opcode == GET)) ? dev_data(t, host_a.a_address) : 32'd0;
      exp_q.push_back(e);
      cur_m  = t;
      a_done = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!(host_a.a_valid && !a_done)) begin
      if ($urandom_range(0, 99) < new_req_pct) new_request();
      else host_a.a_valid = 1'b0;
    end
    a_done = 1'b0;
    host_a.d_ready = ($urandom_range(0, 99) < dready_pct);
    for (int i = 0; i < NUM; i++) begin
      dev_d[i].a_ready = ($urandom_range(0, 3) != 0);
      dev_d[i].d_param = 3'd0;
      dev_d[i].d_sink  = 1'b0;
      dev_d[i].d_error = 1'b0;
      if (dev_q[i].size() > 0) begin
        if (!dv_hold[i] && $urandom_range(0, 2) != 0) dv_hold[i] = 1'b1;
        dev_d[i].d_valid  = dv_hold[i];
        dev_d[i].d_opcode = dev_q[i][0].op;
        dev_d[i].d_source = dev_q[i][0].src;
        dev_d[i].d_size   = dev_q[i][0].size;
        dev_d[i].d_data   = dev_q[i][0].data;
      end else if ((i != cur_m) && $urandom_range(0, 9) == 0) begin
        // stray response from an idle, non-current device
        dev_d[i].d_valid  = 1'b1;
        dev_d[i].d_opcode = ACCESS_ACK_DATA;
        dev_d[i].d_source = 8'($urandom);
        dev_d[i].d_size   = 2'd2;
        dev_d[i].d_data   = $urandom;
      end else begin
        dev_d[i].d_valid  = 1'b0;
      end
    end
    #3;
    check_cycle();
  endtask

  task automatic outputs_low(input string tag);
    host_a.a_valid = 1'b1;
    host_a.d_ready = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      dev_d[i].a_ready = 1'b1;
      dev_d[i].d_valid = 1'b1;
    end
    #1;
    check({tag, "_a_ready"}, host_d.a_ready, 0);
    check({tag, "_d_valid"}, host_d.d_valid, 0);
    for (int i = 0; i < NUM; i++) begin
      check({tag, "_dev_a_valid"}, dev_a[i].a_valid, 0);
      check({tag, "_dev_d_ready"}, dev_a[i].d_ready, 0);
    end
  endtask

  task automatic clear_models();
    exp_q.delete();
    for (int i = 0; i < NUM; i++) begin
      dev_q[i].delete();
      dv_hold[i] = 1'b0;
    end
    cur_m  = 0;
    a_done = 1'b0;
    host_a = '0;
    dev_d  = '0;
  endtask

  // Drop reset between clock edges with traffic in flight.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    outputs_low(tag);
    clear_models();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_models();
    dready_pct   = 90;
    new_req_pct  = 70;
    unmapped_pct = 20;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    host_a.a_address = 32'h0010_0004;
    outputs_low("rst_init");
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;

    repeat (800) step();
    // mostly stalled D channel: fills to MAX_OUT and holds errors
    dready_pct = 15; new_req_pct = 95;
    repeat (800) step();

    dready_pct = 0;
    for (int k = 0; k < 50 && exp_q.size() < 3; k++) step();
    async_reset("rst_busy");

    dready_pct = 60; new_req_pct = 80;
    repeat (1200) step();

    // try to catch an error response in flight, then reset over it
    dready_pct = 0; unmapped_pct = 80;
    for (int k = 0; k < 200 && !(exp_q.size() > 0 && exp_q[0].err); k++) step();
    async_reset("rst_err");

    dready_pct = 90; unmapped_pct = 20; new_req_pct = 70;
    repeat (600) step();

    new_req_pct = 0; dready_pct = 100;
    for (int k = 0; k < 200 && (exp_q.size() > 0 || host_a.a_valid); k++) step();
    check("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
